// File: rtl/stopwatch_key_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_key_ctrl
//
// Button front-end for the stopwatch. Both raw push-button levels are
// synchronised and debounced, then turned into single-cycle command pulses.
// A short press of START toggles run/stop. Holding START for HOLD_MS cycles
// issues a clear. A press of CLEAR issues a clear.
//
// Parameters
//   DEBOUNCE_MS : cycles a synchronised level must persist before the
//                 debounced level follows it (>= 2)
//   HOLD_MS     : cycles START must stay debounced-high in HELD before a
//                 long-press clear is issued (>= 2)
//   CNT_W       : width of the debounce and hold counters; must be able to
//                 hold max(DEBOUNCE_MS, HOLD_MS)
//
// Ports
//   clk         in   1 kHz system clock, shared with the stopwatch
//   rst         in   asynchronous reset, active low
//   key_start   in   raw START button, high = pressed, asynchronous, bouncy
//   key_clear   in   raw CLEAR button, high = pressed, asynchronous, bouncy
//   start_pulse out  one-cycle run/stop toggle command
//   clear_pulse out  one-cycle clear command
//   key_busy    out  high while the START FSM is not in IDLE
// -----------------------------------------------------------------------------
module stopwatch_key_ctrl #(
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 1000,
  parameter int CNT_W       = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic key_start,
  input  logic key_clear,
  output logic start_pulse,
  output logic clear_pulse,
  output logic key_busy
);

  // Debounce counter flips the level on the cycle it would reach DEBOUNCE_MS.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_MS - 1);
  // hold_cnt value seen on the cycle before the long-press clear is issued.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MS - 1);
  // Saturation value of hold_cnt once the long press has been recognised.
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_MS);

  localparam int KEY_START = 0;
  localparam int KEY_CLEAR = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Per-key synchroniser, debouncer and edge detector
  // ---------------------------------------------------------------------------
  logic [1:0] raw;
  logic [1:0] deb;
  logic [1:0] rise;
  logic [1:0] fall;

  assign raw = {key_clear, key_start};

  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    logic             sync1_reg;
    logic             sync2_reg;
    logic             deb_reg;
    logic             deb_next;
    logic             deb_d_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // The counter only advances while the synchronised level disagrees with
    // the debounced level; any agreeing cycle (a bounce back) restarts it.
    always_comb begin
      cnt_next = '0;
      deb_next = deb_reg;
      if (sync2_reg != deb_reg) begin
        if (cnt_reg == DEB_LAST) begin
          deb_next = ~deb_reg;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        deb_reg   <= 1'b0;
        deb_d_reg <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        sync1_reg <= raw[gi];
        sync2_reg <= sync1_reg;
        deb_reg   <= deb_next;
        deb_d_reg <= deb_reg;
        cnt_reg   <= cnt_next;
      end
    end

    assign deb[gi]  = deb_reg;
    assign rise[gi] = deb_reg & ~deb_d_reg;
    assign fall[gi] = ~deb_reg & deb_d_reg;
  end

  // ---------------------------------------------------------------------------
  // START FSM: short press -> toggle, long press -> clear
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic [CNT_W-1:0] hold_cnt_next;
  logic             fsm_start;
  logic             fsm_clear;

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    fsm_start     = 1'b0;
    fsm_clear     = 1'b0;
    case (state_reg)
      IDLE: begin
        hold_cnt_next = '0;
        if (rise[KEY_START]) begin
          state_next = HELD;
        end
      end
      HELD: begin
        // A release always wins over the long-press threshold: any fall seen
        // here happens while hold_cnt is still below HOLD_MS.
        if (fall[KEY_START]) begin
          fsm_start     = 1'b1;
          state_next    = IDLE;
          hold_cnt_next = '0;
        end else if (hold_cnt_reg >= HOLD_LAST) begin
          fsm_clear     = 1'b1;
          state_next    = LONG;
          hold_cnt_next = HOLD_MAX;
        end else begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end
      LONG: begin
        // hold_cnt stays saturated until the key is released.
        hold_cnt_next = HOLD_MAX;
        if (fall[KEY_START]) begin
          state_next    = IDLE;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = IDLE;
        hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Pulse merge and registered outputs
  // ---------------------------------------------------------------------------
  logic start_pulse_reg;
  logic start_pulse_next;
  logic clear_pulse_reg;
  logic clear_pulse_next;

  // A long-press clear and a CLEAR-key press in the same cycle collapse into
  // one pulse. A toggle is dropped whenever a clear goes out in the same
  // cycle, and while CLEAR is held a short-press release is ignored.
  always_comb begin
    clear_pulse_next = fsm_clear | rise[KEY_CLEAR];
    start_pulse_next = fsm_start & ~deb[KEY_CLEAR] & ~clear_pulse_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_pulse_reg <= 1'b0;
      clear_pulse_reg <= 1'b0;
    end else begin
      start_pulse_reg <= start_pulse_next;
      clear_pulse_reg <= clear_pulse_next;
    end
  end

  assign start_pulse = start_pulse_reg;
  assign clear_pulse = clear_pulse_reg;
  assign key_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_key_ctrl
//
// Directed bench for stopwatch_key_ctrl with default parameters. Edge 0 of a
// sequence is the first rising clock edge that samples the scenario's key
// levels. Each table record gives the key waveforms and the hand-computed
// pulse/busy edges; a separate sequence covers reset in the middle of a hold.
// -----------------------------------------------------------------------------
module tb_stopwatch_key_ctrl;

  logic clk;
  logic rst;
  logic key_start;
  logic key_clear;
  logic start_pulse;
  logic clear_pulse;
  logic key_busy;

  int checks;
  int errors;

  // Observations of the most recent sequence.
  int n_start;
  int e_start;
  int n_clear;
  int e_clear;
  int e_rise;
  int e_fall;

  stopwatch_key_ctrl #(
    .DEBOUNCE_MS(20),
    .HOLD_MS    (1000),
    .CNT_W      (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_start  (key_start),
    .key_clear  (key_clear),
    .start_pulse(start_pulse),
    .clear_pulse(clear_pulse),
    .key_busy   (key_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s_on;        // key_start high on edges s_on..s_off
    int s_off;
    int bounce_end;  // before this edge key_start toggles every 5 cycles
    int c_on;        // key_clear high on edges c_on..c_off
    int c_off;
    int run_len;
    int exp_start_cnt;
    int exp_start_edge;
    int exp_clear_cnt;
    int exp_clear_edge;
    int exp_busy_rise;
    int exp_busy_fall;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_seq(input int s_on, input int s_off, input int bounce_end,
                         input int c_on, input int c_off, input int run_len,
                         input int rst_at);
    int prev_busy;
    n_start   = 0;
    e_start   = -1;
    n_clear   = 0;
    e_clear   = -1;
    e_rise    = -1;
    e_fall    = -1;
    prev_busy = 0;
    for (int e = 0; e < run_len; e++) begin
      @(negedge clk);
      if (e < bounce_end) key_start = ((e / 5) % 2) == 0;
      else                key_start = (e >= s_on) && (e <= s_off);
      key_clear = (e >= c_on) && (e <= c_off);
      if (rst_at >= 0 && e == rst_at) begin
        check("busy_before_rst", int'(key_busy), 1);
        rst = 1'b0;
        #1;
        check("rst_start_pulse", int'(start_pulse), 0);
        check("rst_clear_pulse", int'(clear_pulse), 0);
        check("rst_key_busy", int'(key_busy), 0);
      end
      if (rst_at >= 0 && e == rst_at + 3) rst = 1'b1;
      @(posedge clk);
      #1;
      if (start_pulse) begin n_start++; e_start = e; end
      if (clear_pulse) begin n_clear++; e_clear = e; end
      if (key_busy && prev_busy == 0) e_rise = e;
      if (!key_busy && prev_busy == 1) e_fall = e;
      prev_busy = int'(key_busy);
    end
    key_start = 1'b0;
    key_clear = 1'b0;
  endtask

  vec_t  vecs [7];
  string vec_name [7];

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    key_start = 1'b0;
    key_clear = 1'b0;

    //            s_on  s_off  bnc  c_on  c_off  run   #st  e_st  #cl  e_cl  rise  fall
    vecs[0] = '{  0,    99,    0,   0,    -1,    200,  1,   122,  0,   -1,   22,   122};
    vecs[1] = '{  50,   249,   50,  0,    -1,    350,  1,   272,  0,   -1,   72,   272};
    vecs[2] = '{  0,    1499,  0,   0,    -1,    1600, 0,   -1,   1,   1022, 22,   1522};
    vecs[3] = '{  0,    -1,    0,   0,    49,    150,  0,   -1,   1,   22,   -1,   -1};
    vecs[4] = '{  0,    99,    0,   100,  149,   250,  0,   -1,   1,   122,  22,   122};
    vecs[5] = '{  0,    1100,  0,   1000, 1049,  1200, 0,   -1,   1,   1022, 22,   1123};
    vecs[6] = '{  50,   150,   0,   0,    300,   400,  0,   -1,   1,   22,   72,   173};
    vec_name[0] = "short";
    vec_name[1] = "bounce";
    vec_name[2] = "long";
    vec_name[3] = "clear_key";
    vec_name[4] = "simultaneous";
    vec_name[5] = "merge";
    vec_name[6] = "suppress";

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_start_pulse", int'(start_pulse), 0);
    check("reset_clear_pulse", int'(clear_pulse), 0);
    check("reset_key_busy", int'(key_busy), 0);

    for (int i = 0; i < 7; i++) begin
      pulse_reset();
      run_seq(vecs[i].s_on, vecs[i].s_off, vecs[i].bounce_end,
              vecs[i].c_on, vecs[i].c_off, vecs[i].run_len, -1);
      check($sformatf("%s.start_cnt", vec_name[i]), n_start, vecs[i].exp_start_cnt);
      check($sformatf("%s.start_edge", vec_name[i]), e_start, vecs[i].exp_start_edge);
      check($sformatf("%s.clear_cnt", vec_name[i]), n_clear, vecs[i].exp_clear_cnt);
      check($sformatf("%s.clear_edge", vec_name[i]), e_clear, vecs[i].exp_clear_edge);
      check($sformatf("%s.busy_rise", vec_name[i]), e_rise, vecs[i].exp_busy_rise);
      check($sformatf("%s.busy_fall", vec_name[i]), e_fall, vecs[i].exp_busy_fall);
      $display("vec %0d %s: start %0d@%0d clear %0d@%0d busy %0d..%0d",
               i, vec_name[i], n_start, e_start, n_clear, e_clear, e_rise, e_fall);
    end

    // Reset in the middle of a START hold: rst low over edges 500..502, key
    // held through edge 1600. The press restarts at edge 503, so busy rises
    // at 525, the long-press clear lands at 503+1022 = 1525, and release at
    // 1601 brings busy down at 1623.
    pulse_reset();
    run_seq(0, 1600, 0, 0, -1, 1700, 500);
    check("rst_hold.start_cnt", n_start, 0);
    check("rst_hold.clear_cnt", n_clear, 1);
    check("rst_hold.clear_edge", e_clear, 1525);
    check("rst_hold.busy_rise", e_rise, 525);
    check("rst_hold.busy_fall", e_fall, 1623);
    $display("rst_hold: start %0d@%0d clear %0d@%0d busy %0d..%0d",
             n_start, e_start, n_clear, e_clear, e_rise, e_fall);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
